// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings and FSM states.
package muldiv_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_MULT  = 2'b00;
  localparam op_t OP_MULTU = 2'b01;
  localparam op_t OP_DIV   = 2'b10;
  localparam op_t OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    CALC,
    FIX
  } state_e;

  function automatic logic is_signed_op(input op_t op);
    return ~op[0];
  endfunction

  function automatic logic is_div_op(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage handshake and HI/LO bundle between the pipeline and muldiv_unit.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic            start_i;
  op_t             op_i;
  logic [XLEN-1:0] rs_i;
  logic [XLEN-1:0] rt_i;
  logic            flush_i;
  logic            hilo_rd_i;
  logic            hi_we_i;
  logic            lo_we_i;
  logic            busy_o;
  logic            done_o;
  logic            stall_o;
  logic [XLEN-1:0] hi_o;
  logic [XLEN-1:0] lo_o;

  modport master (
    output start_i, op_i, rs_i, rt_i, flush_i, hilo_rd_i, hi_we_i, lo_we_i,
    input  busy_o, done_o, stall_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, rs_i, rt_i, flush_i, hilo_rd_i, hi_we_i, lo_we_i,
    output busy_o, done_o, stall_o, hi_o, lo_o
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO registers; one result bit per cycle,
// multiply and divide sharing a single 2*XLEN accumulator and counter.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk_i,
  input  logic     rst_i,
  muldiv_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);

  state_e            state_q, state_d;
  op_t               op_q, op_d;
  logic [XLEN-1:0]   rs_q, rs_d;
  logic [XLEN-1:0]   rt_q, rt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              rs_neg, rt_neg;
  logic [XLEN-1:0]   rs_abs, rt_abs;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_ext;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic              busy;

  assign rs_neg  = is_signed_op(op_q) & rs_q[XLEN-1];
  assign rt_neg  = is_signed_op(op_q) & rt_q[XLEN-1];
  assign rs_abs  = rs_neg ? -rs_q : rs_q;
  assign rt_abs  = rt_neg ? -rt_q : rt_q;

  // a_q holds the multiplicand or divisor magnitude; acc_q holds {partial, operand}.
  assign mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q};
  assign rem_ext = acc_q[2*XLEN-1:XLEN-1];
  assign trial   = rem_ext - {1'b0, a_q};

  assign prod    = neg_res_q ? -acc_q : acc_q;
  assign quo     = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem     = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  assign busy        = (state_q != IDLE);
  assign bus.busy_o  = busy;
  assign bus.done_o  = done_q;
  assign bus.stall_o = busy & (bus.hilo_rd_i | bus.hi_we_i | bus.lo_we_i);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          state_d = PREP;
          op_d    = bus.op_i;
          rs_d    = bus.rs_i;
          rt_d    = bus.rt_i;
        end
        if (bus.hi_we_i) hi_d = bus.rs_i;
        if (bus.lo_we_i) lo_d = bus.rs_i;
      end

      PREP: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          state_d   = CALC;
          a_d       = is_div_op(op_q) ? rt_abs : rs_abs;
          acc_d     = {{XLEN{1'b0}}, (is_div_op(op_q) ? rs_abs : rt_abs)};
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          cnt_d     = CNT_W'(XLEN);
        end
      end

      CALC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          if (!is_div_op(op_q)) begin
            acc_d = {(acc_q[0] ? mul_sum : {1'b0, acc_q[2*XLEN-1:XLEN]}), acc_q[XLEN-1:1]};
          end else if (trial[XLEN]) begin
            acc_d = {rem_ext[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
          end else begin
            acc_d = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        if (!bus.flush_i) begin
          done_d = 1'b1;
          // Divide by zero reports the raw dividend, bypassing sign correction.
          if (is_div_op(op_q) && (rt_q == '0)) begin
            hi_d = rs_q;
            lo_d = '1;
          end else if (is_div_op(op_q)) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*XLEN-1:XLEN];
            lo_d = prod[XLEN-1:0];
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      op_q      <= OP_MULT;
      rs_q      <= '0;
      rt_q      <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at XLEN=32 plus an XLEN=8 instance.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus ();
  muldiv_if #(.XLEN(8))  bus8 ();

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus8)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input op_t op, input logic [31:0] rs, input logic [31:0] rt);
    exp_t               e;
    logic signed [63:0] sa, sb, p;
    logic [63:0]        u;
    sa = {{32{rs[31]}}, rs};
    sb = {{32{rt[31]}}, rt};
    case (op)
      OP_MULT:  begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      OP_MULTU: begin u = {32'd0, rs} * {32'd0, rt}; e.hi = u[63:32]; e.lo = u[31:0]; end
      OP_DIV: begin
        if (rt == 32'd0) begin e.hi = rs; e.lo = '1; end
        else begin p = sa / sb; e.lo = p[31:0]; p = sa % sb; e.hi = p[31:0]; end
      end
      default: begin
        if (rt == 32'd0) begin e.hi = rs; e.lo = '1; end
        else begin e.lo = rs / rt; e.hi = rs % rt; end
      end
    endcase
    return e;
  endfunction

  task automatic issue(input op_t op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.rs_i    = rs;
    bus.rt_i    = rt;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [31:0] hi, output logic [31:0] lo,
                           output logic busy_at_done);
    lat = -1; hi = '0; lo = '0; busy_at_done = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (bus.done_o) begin
        lat = n; hi = bus.hi_o; lo = bus.lo_o; busy_at_done = bus.busy_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 0; bus.op_i = OP_MULT; bus.rs_i = '0; bus.rt_i = '0;
    bus.flush_i = 0; bus.hilo_rd_i = 0; bus.hi_we_i = 0; bus.lo_we_i = 0;
    bus8.start_i = 0; bus8.op_i = OP_MULT; bus8.rs_i = '0; bus8.rt_i = '0;
    bus8.flush_i = 0; bus8.hilo_rd_i = 0; bus8.hi_we_i = 0; bus8.lo_we_i = 0;
    #12;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done_o); end
    n_checks++; if (bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", bus.hi_o); end
    n_checks++; if (bus.lo_o !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", bus.lo_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mult();
    op_t         ops[4] = '{OP_MULTU, OP_MULT, OP_MULT, OP_MULTU};
    logic [31:0] rss[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0};
    logic [31:0] rts[4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h1234_5678};
    logic [31:0] his[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h4000_0000, 32'd0};
    logic [31:0] los[4] = '{32'h0000_0001, 32'hFFFF_FFF1, 32'h0000_0000, 32'd0};
    exp_t e; int lat; logic [31:0] hi, lo; logic bsy; op_t op; logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        op = ops[i]; a = rss[i]; b = rts[i]; e.hi = his[i]; e.lo = los[i];
      end else begin
        op = (i[0]) ? OP_MULT : OP_MULTU; a = $urandom; b = $urandom; e = model(op, a, b);
      end
      sb_q.push_back(e);
      issue(op, a, b);
      n_checks++; if (bus.busy_o !== 1'b1) begin n_fail++; $display("FAIL mult_busy_rise[%0d]: got %b expected 1", i, bus.busy_o); end
      wait_done(lat, hi, lo, bsy);
      e = sb_q.pop_front();
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency[%0d]: got %0d expected 34", i, lat); end
      n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, hi, e.hi); end
      n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, lo, e.lo); end
      n_checks++; if (bsy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_fall[%0d]: got %b expected 0", i, bsy); end
      @(posedge clk); #1;
      n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse[%0d]: got %b expected 0", i, bus.done_o); end
    end
  endtask

  task automatic test_div();
    op_t         ops[5] = '{OP_DIV, OP_DIVU, OP_DIV, OP_DIV, OP_DIVU};
    logic [31:0] rss[5] = '{32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'hFFFF_FF9C, 32'd50};
    logic [31:0] rts[5] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd7};
    logic [31:0] his[5] = '{32'hFFFF_FFFF, 32'h0000_0064, 32'd0, 32'hFFFF_FF9C, 32'd1};
    logic [31:0] los[5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd7};
    exp_t e; int lat; logic [31:0] hi, lo; logic bsy; op_t op; logic [31:0] a, b;
    for (int i = 0; i < 11; i++) begin
      if (i < 5) begin
        op = ops[i]; a = rss[i]; b = rts[i]; e.hi = his[i]; e.lo = los[i];
      end else begin
        op = (i[0]) ? OP_DIV : OP_DIVU; a = $urandom;
        b = (i < 8) ? $urandom_range(1, 1000) : $urandom;
        e = model(op, a, b);
      end
      sb_q.push_back(e);
      issue(op, a, b);
      wait_done(lat, hi, lo, bsy);
      e = sb_q.pop_front();
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
      n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL div_hi[%0d]: got %h expected %h", i, hi, e.hi); end
      n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL div_lo[%0d]: got %h expected %h", i, lo, e.lo); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev_hi, prev_lo;
    int dones;
    prev_hi = bus.hi_o; prev_lo = bus.lo_o; dones = 0;
    issue(OP_DIVU, 32'd50, 32'd7);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start_i = (c == 5); bus.op_i = OP_MULTU; bus.rs_i = 32'd9; bus.rt_i = 32'd9;
      bus.flush_i = (c == 10);
      @(posedge clk); #1;
      if (bus.done_o) dones++;
    end
    bus.start_i = 0; bus.flush_i = 0;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bus.busy_o); end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done_o || bus.busy_o) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL flush_no_done: got %0d activity cycles expected 0", dones); end
    n_checks++; if (bus.hi_o !== prev_hi) begin n_fail++; $display("FAIL flush_hi: got %h expected %h", bus.hi_o, prev_hi); end
    n_checks++; if (bus.lo_o !== prev_lo) begin n_fail++; $display("FAIL flush_lo: got %h expected %h", bus.lo_o, prev_lo); end
    @(negedge clk);
    bus.start_i = 1; bus.flush_i = 1; bus.op_i = OP_MULTU;
    @(posedge clk); #1;
    bus.start_i = 0; bus.flush_i = 0;
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_idle_start: got busy %b expected 0", bus.busy_o); end
  endtask

  task automatic test_stall();
    logic [31:0] prev_hi;
    exp_t e; int lat; logic [31:0] hi, lo; logic bsy;
    prev_hi = bus.hi_o;
    e.hi = 32'd0; e.lo = 32'd42;
    sb_q.push_back(e);
    issue(OP_MULTU, 32'd6, 32'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.hilo_rd_i = 1; #1;
    n_checks++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL stall_rd: got %b expected 1", bus.stall_o); end
    bus.hilo_rd_i = 0; bus.hi_we_i = 1; bus.rs_i = 32'h1234; #1;
    n_checks++; if (bus.stall_o !== 1'b1) begin n_fail++; $display("FAIL stall_we: got %b expected 1", bus.stall_o); end
    @(posedge clk); #1;
    n_checks++; if (bus.hi_o !== prev_hi) begin n_fail++; $display("FAIL stall_hi_dropped: got %h expected %h", bus.hi_o, prev_hi); end
    @(negedge clk);
    bus.hi_we_i = 0;
    wait_done(lat, hi, lo, bsy);
    e = sb_q.pop_front();
    n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL stall_op_hi: got %h expected %h", hi, e.hi); end
    n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL stall_op_lo: got %h expected %h", lo, e.lo); end
    @(negedge clk);
    bus.hilo_rd_i = 1; #1;
    n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL stall_idle: got %b expected 0", bus.stall_o); end
    bus.hilo_rd_i = 0; bus.hi_we_i = 1; bus.rs_i = 32'h1234;
    @(posedge clk); #1;
    n_checks++; if (bus.hi_o !== 32'h1234) begin n_fail++; $display("FAIL mthi_idle: got %h expected 00001234", bus.hi_o); end
    @(negedge clk);
    bus.hi_we_i = 0; bus.lo_we_i = 1; bus.rs_i = 32'h5678;
    @(posedge clk); #1;
    n_checks++; if (bus.lo_o !== 32'h5678) begin n_fail++; $display("FAIL mtlo_idle: got %h expected 00005678", bus.lo_o); end
    @(negedge clk);
    bus.lo_we_i = 0;
  endtask

  task automatic test_async_reset();
    exp_t e; int lat; logic [31:0] hi, lo; logic bsy;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    repeat (19) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.hi_o !== 32'd0) begin n_fail++; $display("FAIL areset_hi: got %h expected 0", bus.hi_o); end
    n_checks++; if (bus.lo_o !== 32'd0) begin n_fail++; $display("FAIL areset_lo: got %h expected 0", bus.lo_o); end
    n_checks++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b expected 0", bus.busy_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL areset_done: got %b expected 0", bus.done_o); end
    @(negedge clk);
    rst_n = 1'b1;
    e.hi = 32'd0; e.lo = 32'd12;
    sb_q.push_back(e);
    issue(OP_MULTU, 32'd3, 32'd4);
    wait_done(lat, hi, lo, bsy);
    e = sb_q.pop_front();
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 34", lat); end
    n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL post_reset_lo: got %h expected %h", lo, e.lo); end
    n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL post_reset_hi: got %h expected %h", hi, e.hi); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat; logic [31:0] hi, lo; logic bsy;
    @(negedge clk);
    bus.start_i = 1; bus.op_i = OP_MULTU; bus.rs_i = 32'h0000_ABCD; bus.rt_i = 32'd2; bus.hi_we_i = 1;
    e.hi = 32'd0; e.lo = 32'h0001_579A;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.start_i = 0; bus.hi_we_i = 0;
    n_checks++; if (bus.hi_o !== 32'h0000_ABCD) begin n_fail++; $display("FAIL start_mthi_hi: got %h expected 0000abcd", bus.hi_o); end
    wait_done(lat, hi, lo, bsy);
    e = sb_q.pop_front();
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency0: got %0d expected 34", lat); end
    n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL b2b_hi0: got %h expected %h", hi, e.hi); end
    n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL b2b_lo0: got %h expected %h", lo, e.lo); end
    sb_q.push_back(model(OP_DIV, 32'hFFFF_FF00, 32'd3));
    issue(OP_DIV, 32'hFFFF_FF00, 32'd3);
    wait_done(lat, hi, lo, bsy);
    e = sb_q.pop_front();
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL b2b_latency1: got %0d expected 34", lat); end
    n_checks++; if (hi !== e.hi) begin n_fail++; $display("FAIL b2b_hi1: got %h expected %h", hi, e.hi); end
    n_checks++; if (lo !== e.lo) begin n_fail++; $display("FAIL b2b_lo1: got %h expected %h", lo, e.lo); end
  endtask

  task automatic test_xlen8();
    op_t        ops[3] = '{OP_MULTU, OP_DIV, OP_MULT};
    logic [7:0] rss[3] = '{8'hFF, 8'hF9, 8'hFD};
    logic [7:0] rts[3] = '{8'hFF, 8'h02, 8'h05};
    logic [7:0] his[3] = '{8'hFE, 8'hFF, 8'hFF};
    logic [7:0] los[3] = '{8'h01, 8'hFD, 8'hF1};
    exp_t e; int lat; logic [7:0] hi, lo;
    for (int i = 0; i < 3; i++) begin
      e.hi = {24'd0, his[i]}; e.lo = {24'd0, los[i]};
      sb_q.push_back(e);
      @(negedge clk);
      bus8.start_i = 1; bus8.op_i = ops[i]; bus8.rs_i = rss[i]; bus8.rt_i = rts[i];
      @(posedge clk); #1;
      bus8.start_i = 0;
      lat = -1; hi = '0; lo = '0;
      for (int n = 1; n <= 30; n++) begin
        @(posedge clk); #1;
        if (bus8.done_o) begin lat = n; hi = bus8.hi_o; lo = bus8.lo_o; break; end
      end
      e = sb_q.pop_front();
      n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL x8_latency[%0d]: got %0d expected 10", i, lat); end
      n_checks++; if (hi !== e.hi[7:0]) begin n_fail++; $display("FAIL x8_hi[%0d]: got %h expected %h", i, hi, e.hi[7:0]); end
      n_checks++; if (lo !== e.lo[7:0]) begin n_fail++; $display("FAIL x8_lo[%0d]: got %h expected %h", i, lo, e.lo[7:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_stall();
    test_async_reset();
    test_back_to_back();
    test_xlen8();
    n_checks++;
    if (sb_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
